// File: rtl/lc4_fetch_pkg.sv
// Shared types for the LC4 instruction-fetch front end: address/instruction
// widths, the queued fetch entry and one stage of the memory-latency pipe.
package lc4_fetch_pkg;

    localparam int IADDR_MSB = 10;
    localparam int INSN_MSB  = 19;
    localparam int ADDR_W    = IADDR_MSB + 1;
    localparam int INSN_W    = INSN_MSB + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INSN_W-1:0] insn_t;

    typedef struct packed {
        addr_t pc;
        insn_t insn;
    } fetch_entry_t;

    typedef struct packed {
        logic  valid;
        logic  epoch;
        addr_t pc;
    } pipe_stage_t;

    // Sequential fetch address; wraps naturally at the top of the address space.
    function automatic addr_t nextPc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/lc4_insn_fifo.sv
// Small synchronous FIFO of fetched instructions. All updates are gated by
// gwe; flush empties it and overrides any push or pop in the same cycle.
// The head reads as zero while the FIFO is empty.
module lc4_insn_fifo
    import lc4_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gwe,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  fetch_entry_t                 data_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wrPtr_q, wrPtr_d;
    logic [PW-1:0]  rdPtr_q, rdPtr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           doPush;
    logic           doPop;

    // Next pointer/count values; flush wins over push and pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        doPush  = push_i && !flush_i;
        doPop   = pop_i && !flush_i && (count_q != '0);
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PW'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
            count_d = count_q + CW'(doPush) - CW'(doPop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (gwe) begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because the count qualifies them.
    always_ff @(posedge clk) begin
        if (!rst && gwe && doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rdPtr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/lc4_insn_fetch.sv
// LC4 instruction-fetch front end: issues sequential PCs to the i1 memory
// port, tracks reads across a fixed latency pipe, queues returned words and
// squashes stale reads on a redirect using an epoch bit.
module lc4_insn_fetch
    import lc4_fetch_pkg::*;
#(
    parameter int              IADDR    = IADDR_MSB,
    parameter int              INSN     = INSN_MSB,
    parameter int              LATENCY  = 1,
    parameter int              DEPTH    = 4,
    parameter logic [IADDR:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            gwe,
    output logic [IADDR:0]  i1addr,
    output logic            i1re,
    input  logic [INSN:0]   i1out,
    output logic [INSN:0]   insn,
    output logic [IADDR:0]  insn_pc,
    output logic            insn_valid,
    input  logic            insn_ready,
    input  logic            redirect,
    input  logic [IADDR:0]  redirect_pc
);

    localparam int IW = $clog2(LATENCY + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IADDR:0]  pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   fifoCount;
    logic [15:0]     creditSum;
    logic            issueEn;
    logic            pushEn;
    logic            popEn;
    logic            flushEn;
    pipe_stage_t     stageIn;
    pipe_stage_t     tail;
    fetch_entry_t    pushEntry;
    fetch_entry_t    fifoHead;

    // Credit counts queued plus in-flight words before any same-cycle pop.
    assign creditSum = 16'(fifoCount) + 16'(inflight_q) + 16'd1;
    assign i1re      = !rst && !redirect && (creditSum <= 16'(DEPTH));
    assign i1addr    = pc_q;
    assign issueEn   = i1re && gwe;

    assign stageIn   = '{valid: issueEn, epoch: epoch_q, pc: pc_q};

    for (genvar g = 0; g < LATENCY; g++) begin : g_pipe
        pipe_stage_t stage_q;
        pipe_stage_t stageSrc;
        if (g == 0) begin : g_first
            assign stageSrc = stageIn;
        end else begin : g_next
            assign stageSrc = g_pipe[g-1].stage_q;
        end
        // Shift the read tag one stage per gwe-cycle; redirect kills every tag.
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else if (gwe) begin
                stage_q <= redirect ? '0 : stageSrc;
            end
        end
    end

    assign tail      = g_pipe[LATENCY-1].stage_q;
    assign pushEn    = gwe && !redirect && tail.valid && (tail.epoch == epoch_q);
    assign popEn     = gwe && !redirect && insn_valid && insn_ready;
    assign flushEn   = gwe && redirect;
    assign pushEntry = '{pc: tail.pc, insn: i1out};

    // Next pc, epoch and in-flight count; redirect restarts fetch from scratch.
    always_comb begin
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        inflight_d = inflight_q;
        if (redirect) begin
            pc_d       = redirect_pc;
            epoch_d    = ~epoch_q;
            inflight_d = '0;
        end else begin
            if (issueEn) pc_d = nextPc(pc_q);
            inflight_d = inflight_q + IW'(issueEn) - IW'(tail.valid);
        end
    end

    // Fetch state registers, frozen on cycles without gwe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            epoch_q    <= 1'b0;
            inflight_q <= '0;
        end else if (gwe) begin
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            inflight_q <= inflight_d;
        end
    end

    lc4_insn_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .gwe     (gwe),
        .push_i  (pushEn),
        .pop_i   (popEn),
        .flush_i (flushEn),
        .data_i  (pushEntry),
        .head_o  (fifoHead),
        .count_o (fifoCount)
    );

    assign insn       = fifoHead.insn;
    assign insn_pc    = fifoHead.pc;
    assign insn_valid = (fifoCount != '0);

endmodule

// File: tb/tb_lc4_insn_fetch.sv
// Directed bench for lc4_insn_fetch. Three instances share the control inputs:
// A (LATENCY 1, DEPTH 4), B (LATENCY 9, DEPTH 4) and C (LATENCY 3, DEPTH 8,
// RESET_PC 0x7FE). Each has its own memory model: a delay line of issued
// addresses returning word = addr ^ 0xA5A5.
module tb_lc4_insn_fetch;

    logic        clk = 1'b0;
    logic        rst, gwe, ready, redir;
    logic [10:0] redirPc;

    logic [10:0] i1addrA, i1addrB, i1addrC;
    logic        i1reA, i1reB, i1reC;
    logic [19:0] i1outA, i1outB, i1outC;
    logic [19:0] insnA, insnB, insnC;
    logic [10:0] insnPcA, insnPcB, insnPcC;
    logic        validA, validB, validC;

    logic [10:0] lineA [1];
    logic [10:0] lineB [9];
    logic [10:0] lineC [3];

    int          checks = 0;
    int          fails = 0;
    int          overflowCnt = 0;
    int          issues;
    int          stale;
    logic        logC = 1'b0;
    logic [10:0] popQ [$];

    always #5 clk = ~clk;

    lc4_insn_fetch #(.LATENCY(1), .DEPTH(4), .RESET_PC(11'h000)) dutA (
        .clk(clk), .rst(rst), .gwe(gwe), .i1addr(i1addrA), .i1re(i1reA), .i1out(i1outA),
        .insn(insnA), .insn_pc(insnPcA), .insn_valid(validA), .insn_ready(ready),
        .redirect(redir), .redirect_pc(redirPc));

    lc4_insn_fetch #(.LATENCY(9), .DEPTH(4), .RESET_PC(11'h000)) dutB (
        .clk(clk), .rst(rst), .gwe(gwe), .i1addr(i1addrB), .i1re(i1reB), .i1out(i1outB),
        .insn(insnB), .insn_pc(insnPcB), .insn_valid(validB), .insn_ready(ready),
        .redirect(redir), .redirect_pc(redirPc));

    lc4_insn_fetch #(.LATENCY(3), .DEPTH(8), .RESET_PC(11'h7FE)) dutC (
        .clk(clk), .rst(rst), .gwe(gwe), .i1addr(i1addrC), .i1re(i1reC), .i1out(i1outC),
        .insn(insnC), .insn_pc(insnPcC), .insn_valid(validC), .insn_ready(ready),
        .redirect(redir), .redirect_pc(redirPc));

    function automatic logic [19:0] memWord(input logic [10:0] a);
        return {9'b0, a} ^ 20'h0A5A5;
    endfunction

    // Memory models: addresses advance one slot per gwe-cycle.
    always @(posedge clk) begin
        if (gwe) begin
            lineA[0] <= i1addrA;
            lineB[0] <= i1addrB;
            for (int k = 1; k < 9; k++) lineB[k] <= lineB[k-1];
            lineC[0] <= i1addrC;
            for (int k = 1; k < 3; k++) lineC[k] <= lineC[k-1];
        end
    end

    assign i1outA = memWord(lineA[0]);
    assign i1outB = memWord(lineB[8]);
    assign i1outC = memWord(lineC[2]);

    // Pushing into a full FIFO must never happen.
    always @(negedge clk) begin
        if (!rst) begin
            if (dutA.pushEn && int'(dutA.fifoCount) == 4) overflowCnt++;
            if (dutB.pushEn && int'(dutB.fifoCount) == 4) overflowCnt++;
            if (dutC.pushEn && int'(dutC.fifoCount) == 8) overflowCnt++;
        end
    end

    // Record every pc that decode accepts from instance C.
    always @(negedge clk) begin
        if (logC && !rst && gwe && validC && ready) popQ.push_back(insnPcC);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic g, input logic rd,
                                 input logic rdir, input logic [10:0] rpc);
        rst = r; gwe = g; ready = rd; redir = rdir; redirPc = rpc;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAll();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 11'h000);
        nextCycle();
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset values
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'h000);
        nextCycle();
        nextCycle();
        checkOutput("rstI1re", 32'(i1reA), 0);
        checkOutput("rstI1addr", 32'(i1addrA), 0);
        checkOutput("rstValid", 32'(validA), 0);
        checkOutput("rstInsn", 32'(insnA), 0);
        checkOutput("rstInsnPc", 32'(insnPcA), 0);
        checkOutput("rstI1addrC", 32'(i1addrC), 32'h7FE);
        checkOutput("rstValidB", 32'(validB), 0);

        // Stream with decode always ready, LATENCY 1
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h000);
        checkOutput("streamFirstIssue", 32'(i1reA), 1);
        checkOutput("streamFirstAddr", 32'(i1addrA), 0);
        nextCycle();
        checkOutput("streamNotYet", 32'(validA), 0);
        nextCycle();
        for (int k = 0; k < 6; k++) begin
            checkOutput("streamValid", 32'(validA), 1);
            checkOutput("streamPc", 32'(insnPcA), 32'(k));
            checkOutput("streamInsn", 32'(insnA), 32'(memWord(11'(k))));
            nextCycle();
        end

        // Redirect coinciding with pop and push on instance A
        resetAll();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
        repeat (4) nextCycle();
        checkOutput("coinHeadValid", 32'(validA), 1);
        checkOutput("coinHeadPc", 32'(insnPcA), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'h040);
        checkOutput("coinNoIssue", 32'(i1reA), 0);
        nextCycle();
        checkOutput("coinFlushed", 32'(validA), 0);
        checkOutput("coinNewAddr", 32'(i1addrA), 32'h040);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h000);
        nextCycle();
        checkOutput("coinStillEmpty", 32'(validA), 0);
        nextCycle();
        checkOutput("coinFirstValid", 32'(validA), 1);
        checkOutput("coinFirstPc", 32'(insnPcA), 32'h040);
        checkOutput("coinFirstInsn", 32'(insnA), 32'(memWord(11'h040)));
        nextCycle();
        checkOutput("coinSecondPc", 32'(insnPcA), 32'h041);

        // Backpressure on instance B, LATENCY 9
        resetAll();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
        issues = 0;
        for (int i = 1; i <= 13; i++) begin
            if (i1reB) issues++;
            nextCycle();
        end
        checkOutput("bpIssueCount", 32'(issues), 4);
        checkOutput("bpFullValid", 32'(validB), 1);
        checkOutput("bpHeadPc0", 32'(insnPcB), 0);
        checkOutput("bpHeadInsn0", 32'(insnB), 32'(memWord(11'h000)));
        checkOutput("bpStalled", 32'(i1reB), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h000);
        checkOutput("bpNoIssueOnPop", 32'(i1reB), 0);
        nextCycle();
        checkOutput("bpHeadPc1", 32'(insnPcB), 1);
        checkOutput("bpResume", 32'(i1reB), 1);
        checkOutput("bpResumeAddr", 32'(i1addrB), 4);
        nextCycle();
        checkOutput("bpHeadPc2", 32'(insnPcB), 2);
        nextCycle();
        checkOutput("bpHeadPc3", 32'(insnPcB), 3);
        nextCycle();
        checkOutput("bpDrained", 32'(validB), 0);

        // Redirect with reads in flight on instance B
        resetAll();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h000);
        repeat (4) nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'h120);
        checkOutput("rdNoIssue", 32'(i1reB), 0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h000);
        checkOutput("rdNewAddr", 32'(i1addrB), 32'h120);
        checkOutput("rdIssue", 32'(i1reB), 1);
        stale = 0;
        for (int i = 6; i <= 15; i++) begin
            if (validB) stale++;
            nextCycle();
        end
        checkOutput("rdNoStale", 32'(stale), 0);
        checkOutput("rdFirstValid", 32'(validB), 1);
        checkOutput("rdFirstPc", 32'(insnPcB), 32'h120);
        checkOutput("rdFirstInsn", 32'(insnB), 32'(memWord(11'h120)));
        nextCycle();
        checkOutput("rdSecondPc", 32'(insnPcB), 32'h121);

        // gwe stall and address wrap on instance C
        resetAll();
        logC = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic        g;
            logic [10:0] a0;
            logic        v0;
            logic [10:0] p0;
            g = (i % 2 == 0);
            applyStimulus(1'b0, g, 1'b1, 1'b0, 11'h000);
            a0 = i1addrC;
            v0 = validC;
            p0 = insnPcC;
            nextCycle();
            if (!g) begin
                checkOutput("stallAddr", 32'(i1addrC), 32'(a0));
                checkOutput("stallValid", 32'(validC), 32'(v0));
                checkOutput("stallPc", 32'(insnPcC), 32'(p0));
            end
        end
        logC = 1'b0;
        checkOutput("wrapPopCount", 32'(popQ.size()), 6);
        if (popQ.size() >= 4) begin
            checkOutput("wrapPc0", 32'(popQ[0]), 32'h7FE);
            checkOutput("wrapPc1", 32'(popQ[1]), 32'h7FF);
            checkOutput("wrapPc2", 32'(popQ[2]), 32'h000);
            checkOutput("wrapPc3", 32'(popQ[3]), 32'h001);
        end

        // Reset mid-flight on instance C: 2 queued, 3 in flight
        resetAll();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
        repeat (5) nextCycle();
        checkOutput("mfQueued", 32'(validC), 1);
        checkOutput("mfHeadPc", 32'(insnPcC), 32'h7FE);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 11'h000);
        nextCycle();
        checkOutput("mfValidCleared", 32'(validC), 0);
        checkOutput("mfAddrReset", 32'(i1addrC), 32'h7FE);
        checkOutput("mfInsnCleared", 32'(insnC), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h000);
        stale = 0;
        for (int i = 7; i <= 10; i++) begin
            if (validC) stale++;
            nextCycle();
        end
        checkOutput("mfNoStale", 32'(stale), 0);
        checkOutput("mfFirstValid", 32'(validC), 1);
        checkOutput("mfFirstPc", 32'(insnPcC), 32'h7FE);
        checkOutput("mfFirstInsn", 32'(insnC), 32'(memWord(11'h7FE)));
        nextCycle();
        checkOutput("mfSecondPc", 32'(insnPcC), 32'h7FF);

        checkOutput("noOverflow", 32'(overflowCnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
